alu_bist: RTL and testbench
===========================

# alu_bist

Built-in self-test controller that sits on the driving side of the 32-bit `alu` operand/function interface. It generates pseudo-random operand pairs and cycles through all seven function codes. It samples the ALU result and carry, and checks each against an internal golden model. It reports an error count and a pass flag, so ALU silicon or FPGA builds are checked in-system without a simulator bench.

## Interface
- `NVEC`, default 100: number of passes; each pass issues all 7 function codes with fresh operands.
- `SEED`, default 32'hACE1_2025: LFSR seed loaded on each start. A zero value is replaced by 32'h1.
- `i_clk` in, 1 bit: the single clock.
- `i_rstn` in, 1 bit: reset, asynchronous and active-low.
- `i_start` in, 1 bit: start pulse; sampled only in IDLE or DONE.
- `o_busy` out, 1 bit: high while the test runs.
- `o_done` out, 1 bit: high from run completion until the next start or reset.
- `o_pass` out, 1 bit: `o_done && (o_err_cnt == 0)`, registered.
- `o_err_cnt` out, 16 bits: number of mismatches; saturates at 16'hFFFF.
- `o_alu_a` and `o_alu_b` out, 32 bits each: operands to the ALU `i_a` and `i_b`.
- `o_alu_f` out, 3 bits: function code to the ALU `i_f`.
- `i_alu_y` in, 32 bits: ALU result (`o_y`).
- `i_alu_c` in, 1 bit: ALU carry (`o_c`).
- `o_sig` out, 32 bits: result signature; present only with `ALU_BIST_SIGNATURE_EN`.

## Operation
- FSM states: IDLE, LOAD, CHECK, DONE.
  - IDLE/DONE to LOAD on `i_start`. This transition reloads the LFSR with `SEED` and clears `o_err_cnt`, `o_done`, `o_pass`, the pass counter and the code index.
  - LOAD to CHECK always.
  - CHECK to LOAD while operations remain; CHECK to DONE after the last operation.
- Function code order within a pass: 000, 001, 010, 100, 101, 110, 111. Code 011 is never issued.
- Operand generation in LOAD:
  - LFSR is Galois, 32-bit, with mask 32'h8020_0003 (x^32+x^22+x^2+x+1).
  - `a = next(s)`, `b = next(next(s))`, then `s <= b`.
  - `o_alu_a`, `o_alu_b` and `o_alu_f` are registered at this edge.
- Golden model, computed on the registered operands:
  - 000: `a&b`.
  - 001: `a|b`.
  - 010: `a+b`, with c = bit 32 of the 33-bit sum.
  - 100: `a&~b`.
  - 101: `a|~b`.
  - 110: `a+~b+1`, with c = bit 32 of that sum.
  - 111: `y = {31'b0, signed a < signed b}`.
- Checking in CHECK:
  - Compare `i_alu_y` with the golden y for every code.
  - Compare `i_alu_c` with the golden c only for codes 010 and 110. The carry is don't-care for all other codes.
  - Any mismatch increments `o_err_cnt` by 1 (saturating); at most one increment per operation.
- `i_start` is ignored in LOAD and CHECK.
- Reset values: all outputs 0, state IDLE, LFSR = `SEED`.
- Asserting `i_rstn` mid-run aborts immediately. No partial result is retained.
- `o_alu_*` hold their last driven values in DONE.

## Timing
- The ALU is combinational. `i_alu_y`/`i_alu_c` must settle within the CHECK cycle that follows LOAD.
- Each operation takes 2 cycles.
- Let E0 be the edge that samples `i_start`:
  - Operation 0 is driven at edge E0+1.
  - `o_busy` is 1 from E0 through E0+14·NVEC−1.
  - `o_done` and `o_pass` rise at E0+14·NVEC, the final CHECK edge, when `o_busy` falls.
- `o_err_cnt` updates at each CHECK edge and is stable once `o_done` is high.

## Configuration
- `ALU_BIST_SIGNATURE_EN` defined:
  - Adds `o_sig`, a MISR: at each CHECK edge, `sig <= next(sig) ^ i_alu_y`, using the same LFSR mask.
  - `o_sig` is cleared by reset and by start.
- Undefined: no `o_sig` port and no MISR logic.
- Pass/fail behaviour is identical in both builds.

## Structure
- Shared header `alu_bist_defs.vh` holds:
  - function-code localparams (shared with `alu`);
  - the LFSR mask;
  - the FSM state encodings.
- Sub-module `alu_bist_ref` is the combinational golden model: inputs a, b, f; outputs y, c, and a carry-valid flag. It is reusable by benches.
- The LFSR next-state function is a Verilog function in the header.

## Test plan
- Reset: hold `i_rstn`=0 → all outputs 0; with `i_start` held high during reset, `o_busy` stays 0 until release.
- Nominal run: NVEC=1 with a correct `alu` attached, start pulse → first op `o_alu_f`=000 and `o_alu_a`=next(SEED); `o_done`=1 exactly 14 cycles after E0; `o_pass`=1; `o_err_cnt`=0.
- Stuck-at fault: force `i_alu_y[0]`=1 → `o_err_cnt` equals the bench-counted number of ops whose golden y[0]=0; `o_pass`=0.
- Carry fault: force `i_alu_c`=0 → errors appear only on 010/110 ops whose golden c=1; 111 ops never count.
- Start and abort: pulse `i_start` mid-run → ignored. Drop `i_rstn` at op 3 → IDLE; a restart reproduces the identical a/b sequence.
- Signature: with `ALU_BIST_SIGNATURE_EN` and a correct ALU, two runs give the same `o_sig`; flipping one result bit changes `o_sig`.

Source files
------------

// File: rtl/alu_bist_pkg.sv
// Shared definitions for the ALU built-in self-test: function codes,
// LFSR mask, FSM states and the LFSR/op-order helpers.
package alu_bist_pkg;

    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_ANDN = 3'b100;
    localparam logic [2:0] F_ORN  = 3'b101;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_SLT  = 3'b111;

    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

    // Index 0..6 maps onto the seven codes, skipping 011.
    function automatic logic [2:0] op_code(input logic [2:0] idx);
        return (idx < 3'd3) ? idx : idx + 3'd1;
    endfunction

endpackage

// File: rtl/alu_bist_ref.sv
// Combinational golden ALU model: result, carry and carry-valid flag.
module alu_bist_ref
    import alu_bist_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [2:0]  i_f,
    output logic [31:0] o_y,
    output logic        o_c,
    output logic        o_cv
);

    logic        is_sub;
    logic [32:0] sum;

    always_comb begin
        is_sub = (i_f == F_SUB);
        sum    = {1'b0, i_a} + {1'b0, is_sub ? ~i_b : i_b} + {32'b0, is_sub};
        o_y    = '0;
        o_c    = 1'b0;
        o_cv   = 1'b0;
        case (i_f)
            F_AND:  o_y = i_a & i_b;
            F_OR:   o_y = i_a | i_b;
            F_ANDN: o_y = i_a & ~i_b;
            F_ORN:  o_y = i_a | ~i_b;
            F_ADD, F_SUB: begin
                o_y  = sum[31:0];
                o_c  = sum[32];
                o_cv = 1'b1;
            end
            F_SLT:  o_y = {31'b0, $signed(i_a) < $signed(i_b)};
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/alu_bist.sv
// ALU BIST controller: LFSR operands, all seven codes per pass, golden check.
// Optional MISR result signature on o_sig when ALU_BIST_SIGNATURE_EN is defined.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int          NVEC = 100,
    parameter logic [31:0] SEED = 32'hACE1_2025
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_err_cnt,
    output logic [31:0] o_alu_a,
    output logic [31:0] o_alu_b,
    output logic [2:0]  o_alu_f,
`ifdef ALU_BIST_SIGNATURE_EN
    output logic [31:0] o_sig,
`endif
    input  logic [31:0] i_alu_y,
    input  logic        i_alu_c
);

    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam int          PW      = (NVEC > 1) ? $clog2(NVEC) : 1;
    localparam logic [PW-1:0] LAST_PASS = PW'(NVEC - 1);

    state_e        state_q, state_d;
    logic [31:0]   lfsr_q, lfsr_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [2:0]    f_q, f_d;
    logic [2:0]    idx_q, idx_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [15:0]   err_q, err_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
`ifdef ALU_BIST_SIGNATURE_EN
    logic [31:0]   sig_q, sig_d;
`endif

    logic [31:0] gold_y, na, nb;
    logic        gold_c, gold_cv, mism, last;
    logic [15:0] err_inc;

    alu_bist_ref u_ref (
        .i_a  (a_q),
        .i_b  (b_q),
        .i_f  (f_q),
        .o_y  (gold_y),
        .o_c  (gold_c),
        .o_cv (gold_cv)
    );

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        idx_d   = idx_q;
        pcnt_d  = pcnt_q;
        err_d   = err_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
`ifdef ALU_BIST_SIGNATURE_EN
        sig_d   = sig_q;
`endif
        na      = lfsr_next(lfsr_q);
        nb      = lfsr_next(na);
        mism    = (i_alu_y != gold_y) || (gold_cv && (i_alu_c != gold_c));
        err_inc = (mism && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
        last    = (idx_q == 3'd6) && (pcnt_q == LAST_PASS);
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = S_LOAD;
                    lfsr_d  = SEED_NZ;
                    idx_d   = '0;
                    pcnt_d  = '0;
                    err_d   = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
`ifdef ALU_BIST_SIGNATURE_EN
                    sig_d   = '0;
`endif
                end
            end
            S_LOAD: begin
                state_d = S_CHECK;
                a_d     = na;
                b_d     = nb;
                f_d     = op_code(idx_q);
                lfsr_d  = nb;
            end
            S_CHECK: begin
                err_d = err_inc;
`ifdef ALU_BIST_SIGNATURE_EN
                sig_d = lfsr_next(sig_q) ^ i_alu_y;
`endif
                if (last) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_inc == 16'd0);
                end else begin
                    state_d = S_LOAD;
                    if (idx_q == 3'd6) begin
                        idx_d  = '0;
                        pcnt_d = pcnt_q + PW'(1);
                    end else begin
                        idx_d  = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_NZ;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            idx_q   <= '0;
            pcnt_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
`ifdef ALU_BIST_SIGNATURE_EN
            sig_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            idx_q   <= idx_d;
            pcnt_q  <= pcnt_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
`ifdef ALU_BIST_SIGNATURE_EN
            sig_q   <= sig_d;
`endif
        end
    end

    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_pass    = pass_q;
    assign o_err_cnt = err_q;
    assign o_alu_a   = a_q;
    assign o_alu_b   = b_q;
    assign o_alu_f   = f_q;
`ifdef ALU_BIST_SIGNATURE_EN
    assign o_sig     = sig_q;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: behavioural ALU with fault injection, NVEC=2 runs,
// operand table from an independent LFSR model.
module tb_alu_bist;

    localparam int NV   = 2;
    localparam int NOPS = 7 * NV;
    localparam int RUNC = 14 * NV;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        c;
        logic        cv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [31:0] alu_a, alu_b, alu_y;
    logic [2:0]  alu_f;
    logic        alu_c;
`ifdef ALU_BIST_SIGNATURE_EN
    logic [31:0] sig;
`endif

    int   fmode = 0;
    int   n_chk = 0;
    int   n_err = 0;
    vec_t tbl[NOPS];

    always #5 clk = ~clk;

    alu_bist #(.NVEC(NV), .SEED(32'hACE1_2025)) dut (
        .i_clk     (clk),
        .i_rstn    (rstn),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_pass    (pass),
        .o_err_cnt (err_cnt),
        .o_alu_a   (alu_a),
        .o_alu_b   (alu_b),
        .o_alu_f   (alu_f),
`ifdef ALU_BIST_SIGNATURE_EN
        .o_sig     (sig),
`endif
        .i_alu_y   (alu_y),
        .i_alu_c   (alu_c)
    );

    function automatic logic [31:0] nx(input logic [31:0] s);
        logic [31:0] r;
        r = {1'b0, s[31:1]};
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [32:0] gold(input logic [31:0] a,
                                         input logic [31:0] b,
                                         input logic [2:0] f);
        case (f)
            3'b000: return {1'b0, a & b};
            3'b001: return {1'b0, a | b};
            3'b010: return {1'b0, a} + {1'b0, b};
            3'b100: return {1'b0, a & ~b};
            3'b101: return {1'b0, a | ~b};
            3'b110: return {a >= b, a - b};
            3'b111: return {32'b0, $signed(a) < $signed(b)};
            default: return 33'b0;
        endcase
    endfunction

    always_comb begin
        logic [32:0] g;
        g     = gold(alu_a, alu_b, alu_f);
        alu_y = g[31:0];
        alu_c = g[32];
        if (fmode == 1) alu_y[0] = 1'b1;
        if (fmode == 2) alu_c = 1'b0;
        if (fmode == 3 && alu_f == 3'b001) alu_y[5] = ~alu_y[5];
        if (fmode == 4 && alu_f != 3'b010 && alu_f != 3'b110) alu_c = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic int exp_errs(input int mode);
        int n = 0;
        for (int k = 0; k < NOPS; k++) begin
            case (mode)
                1: if (!tbl[k].y[0]) n++;
                2: if (tbl[k].cv && tbl[k].c) n++;
                3: if (tbl[k].f == 3'b001) n++;
                default: n = n;
            endcase
        end
        return n;
    endfunction

    task automatic run(input int mode, input bit mid_start);
        int ee;
        ee    = exp_errs(mode);
        fmode = mode;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_e0", busy, 1);
        chk("done_e0", done, 0);
        for (int c = 1; c <= RUNC; c++) begin
            @(posedge clk);
            #1;
            if (c % 2 == 1) begin
                chk("op_f", alu_f, tbl[(c-1)/2].f);
                chk("op_a", alu_a, tbl[(c-1)/2].a);
                chk("op_b", alu_b, tbl[(c-1)/2].b);
            end
            if (c == 1) begin
                chk("op0_a_hand", alu_a, 32'hD650_9011);
                chk("op0_b_hand", alu_b, 32'hEB08_480B);
            end
            chk("busy", busy, c < RUNC);
            if (c < RUNC) chk("done_early", done, 0);
            start = (mid_start && c == 5);
        end
        start = 1'b0;
        chk("done", done, 1);
        chk("pass", pass, ee == 0);
        chk("err_cnt", err_cnt, ee);
        fmode = 0;
    endtask

    initial begin
        logic [31:0] s;
        logic [32:0] g;
        logic [2:0]  codes[7];
        int          e;
`ifdef ALU_BIST_SIGNATURE_EN
        logic [31:0] sig1;
`endif
        codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
        s = 32'hACE1_2025;
        for (int k = 0; k < NOPS; k++) begin
            tbl[k].f  = codes[k % 7];
            tbl[k].a  = nx(s);
            tbl[k].b  = nx(tbl[k].a);
            s         = tbl[k].b;
            g         = gold(tbl[k].a, tbl[k].b, tbl[k].f);
            tbl[k].y  = g[31:0];
            tbl[k].c  = g[32];
            tbl[k].cv = (tbl[k].f == 3'b010 || tbl[k].f == 3'b110);
        end

        rstn  = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_a", alu_a, 0);
        chk("rst_b", alu_b, 0);
        chk("rst_f", alu_f, 0);
        @(negedge clk);
        start = 1'b0;
        rstn  = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);

        run(0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", done, 1);
        chk("hold_f", alu_f, tbl[NOPS-1].f);

        run(1, 1'b0);
        e = exp_errs(1);
        chk("y0_nonzero", e > 0, 1);
        run(2, 1'b0);
        run(4, 1'b0);
        run(0, 1'b1);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
        end
        chk("abort_op3_a", alu_a, tbl[3].a);
        rstn = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_a", alu_a, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        rstn = 1'b1;
        run(0, 1'b0);

`ifdef ALU_BIST_SIGNATURE_EN
        sig1 = sig;
        run(0, 1'b0);
        chk("sig_repeat", sig, sig1);
        run(3, 1'b0);
        chk("sig_changed", sig != sig1, 1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
